// File: rtl/sh4_fpu_pack_if.sv
// sh4_fpu_pack_if: unpacked-result in, packed IEEE single out.
// No backpressure; the packer accepts every valid cycle.
interface sh4_fpu_pack_if;
  logic        i_valid;
  logic [4:0]  i_tag;
  logic        i_sign;
  logic [10:0] i_exp;
  logic [24:0] i_frac;
  logic        i_is_zero;
  logic        i_is_inf;
  logic        i_is_nan;
  logic        i_invalid;
  logic        i_rm;
  logic        i_flush;
  logic        i_flag_clr;
  logic        o_valid;
  logic [4:0]  o_tag;
  logic [31:0] o_data;
  logic [4:0]  o_cause;
  logic [4:0]  o_flags;

  modport master (
    output i_valid, i_tag, i_sign, i_exp, i_frac,
    output i_is_zero, i_is_inf, i_is_nan, i_invalid,
    output i_rm, i_flush, i_flag_clr,
    input  o_valid, o_tag, o_data, o_cause, o_flags
  );

  modport slave (
    input  i_valid, i_tag, i_sign, i_exp, i_frac,
    input  i_is_zero, i_is_inf, i_is_nan, i_invalid,
    input  i_rm, i_flush, i_flag_clr,
    output o_valid, o_tag, o_data, o_cause, o_flags
  );
endinterface

// File: rtl/sh4_fpu_pack.sv
// sh4_fpu_pack: 2-stage round/pack of an unpacked FPU result
// into IEEE-754 single with per-result and sticky flags.
module sh4_fpu_pack (
  input logic          clk,
  input logic          rst_n,
  sh4_fpu_pack_if.slave bus
);

  typedef enum logic [1:0] {
    C_NUM,
    C_ZERO,
    C_INF,
    C_NAN
  } cls_e;

  logic               s1_valid;
  logic [4:0]         s1_tag;
  logic               s1_sign;
  logic               s1_rm;
  logic               s1_inv;
  logic signed [11:0] s1_e;
  logic [22:0]        s1_frac;
  logic               s1_inc;
  logic               s1_inx;
  cls_e               s1_cls;

  logic signed [11:0] e_in;
  logic               inc_in;
  cls_e               cls_in;

  logic [23:0]        fsum;
  logic               carry;
  logic signed [11:0] e_r;
  logic               uf;
  logic               of;
  logic [31:0]        data_nx;
  logic [4:0]         cause_nx;
  logic               v2_nx;

  assign e_in = $signed({bus.i_exp[10], bus.i_exp})
              + 12'sd127;

  assign inc_in = ~bus.i_rm & bus.i_frac[1]
                & (bus.i_frac[0] | bus.i_frac[2]);

  // Special-case class, NaN winning over Inf over zero.
  always_comb begin
    cls_in = C_NUM;
    priority case (1'b1)
      bus.i_is_nan:  cls_in = C_NAN;
      bus.i_is_inf:  cls_in = C_INF;
      bus.i_is_zero: cls_in = C_ZERO;
      default:       cls_in = C_NUM;
    endcase
  end

  // Stage 1 valid; a flush drops the incoming entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s1_valid <= 1'b0;
    else        s1_valid <= bus.i_valid & ~bus.i_flush;
  end

  // Stage 1 payload, loaded only for a valid input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_tag  <= '0;
      s1_sign <= 1'b0;
      s1_rm   <= 1'b0;
      s1_inv  <= 1'b0;
      s1_e    <= '0;
      s1_frac <= '0;
      s1_inc  <= 1'b0;
      s1_inx  <= 1'b0;
      s1_cls  <= C_NUM;
    end else if (bus.i_valid) begin
      s1_tag  <= bus.i_tag;
      s1_sign <= bus.i_sign;
      s1_rm   <= bus.i_rm;
      s1_inv  <= bus.i_invalid;
      s1_e    <= e_in;
      s1_frac <= bus.i_frac[24:2];
      s1_inc  <= inc_in;
      s1_inx  <= bus.i_frac[1] | bus.i_frac[0];
      s1_cls  <= cls_in;
    end
  end

  // The hidden 1 is left implicit: a carry past bit 22
  // means 1.f rounded up to 2.0, and fsum[22:0] is then 0.
  assign fsum  = {1'b0, s1_frac} + {23'd0, s1_inc};
  assign carry = fsum[23];
  assign e_r   = s1_e + $signed({11'd0, carry});
  assign uf    = s1_e <= 12'sd0;
  assign of    = e_r >= 12'sd255;
  assign v2_nx = s1_valid & ~bus.i_flush;

  // Stage 2 result and cause selection.
  always_comb begin
    data_nx  = '0;
    cause_nx = '0;
    unique case (s1_cls)
      C_NAN:  data_nx = 32'h7FBF_FFFF;
      C_INF:  data_nx = {s1_sign, 8'hFF, 23'h0};
      C_ZERO: data_nx = {s1_sign, 31'h0};
      C_NUM: begin
        if (uf) begin
          data_nx  = {s1_sign, 31'h0};
          cause_nx = 5'b00011;
        end else if (of) begin
          cause_nx = 5'b00101;
          data_nx  = s1_rm
                   ? {s1_sign, 8'hFE, 23'h7F_FFFF}
                   : {s1_sign, 8'hFF, 23'h0};
        end else begin
          data_nx  = {s1_sign, e_r[7:0], fsum[22:0]};
          cause_nx = {4'b0, s1_inx};
        end
      end
      default: data_nx = '0;
    endcase
    cause_nx[4] = s1_inv;
  end

  // Output valid; killed entries never reach the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.o_valid <= 1'b0;
    else        bus.o_valid <= v2_nx;
  end

  // Output payload, held while no result is produced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.o_tag   <= '0;
      bus.o_data  <= '0;
      bus.o_cause <= '0;
    end else if (v2_nx) begin
      bus.o_tag   <= s1_tag;
      bus.o_data  <= data_nx;
      bus.o_cause <= cause_nx;
    end
  end

  // Sticky flags; a new cause survives a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      bus.o_flags <= '0;
    else
      bus.o_flags <= (bus.i_flag_clr ? 5'h0 : bus.o_flags)
                   | (v2_nx ? cause_nx : 5'h0);
  end

endmodule

// File: doc/sh4_fpu_pack.md
SH4_FPU_PACK -- requirements
Module: sh4_fpu_pack

Interface
REQ-001 The block SHALL have one clock, clk, and one reset, rst_n, which is asynchronous and active-low.
REQ-002 Ports SHALL be as follows:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  unpacked result present this cycle.
- i_tag  in  5  destination tag.
- i_sign  in  1  result sign.
- i_exp  in  11  signed two's-complement unbiased exponent.
- i_frac  in  25  [24:2] fraction below implicit 1, [1] guard, [0] sticky.
- i_is_zero, i_is_inf, i_is_nan  in  1 each  special-value flags.
- i_invalid  in  1  upstream invalid-operation indication.
- i_rm  in  1  rounding mode: 0 = round-nearest-even, 1 = round-toward-zero.
- i_flush  in  1  synchronous pipeline kill.
- i_flag_clr  in  1  clear sticky flags.
- o_valid  out  1  packed result valid.
- o_tag  out  5  tag of the result.
- o_data  out  32  IEEE-754 single.
- o_cause  out  5  per-result flags: [4]V [3]Z [2]O [1]U [0]I.
- o_flags  out  5  sticky OR of o_cause, same bit order.

Function
REQ-003 The pipeline SHALL be 2 stages with fixed latency 2 and no backpressure; a result is accepted every cycle that i_valid=1.
REQ-004 i_tag, i_rm and i_invalid SHALL travel with the operand; o_tag SHALL equal the tag accepted 2 cycles earlier.
REQ-005 Stage 1 SHALL register the biased exponent E=i_exp+127 (computed at 12 bits, signed), the rounding increment, and the special-case class.
REQ-006 In RN mode, the increment SHALL be guard&(sticky|frac[2]); in RZ mode, the increment SHALL be 0.
REQ-007 Inexact SHALL be guard|sticky on the numeric path.
REQ-008 Stage 2 SHALL add the increment to {1,frac[24:2]}; if that sum carries out to 2.0, the fraction SHALL become 0 and E SHALL increment by 1.
REQ-009 Class priority SHALL be nan > inf > zero > numeric.
REQ-010 NaN SHALL output 0x7FBFFFFF; V SHALL be set if i_invalid=1.
REQ-011 Inf SHALL output {sign,8'hFF,23'h0} with no flags.
REQ-012 Zero SHALL output {sign,31'h0} with no flags.
REQ-013 Overflow is post-round E>=255; it SHALL set O and I and output {sign,8'hFF,0} in RN mode or {sign,8'hFE,23'h7FFFFF} in RZ mode.
REQ-014 Underflow is pre-round E<=0; it SHALL flush to {sign,31'h0} and set U and I, with no denormal output.
REQ-015 Normal output SHALL be {sign,E[7:0],rounded frac}, with I set per REQ-007.
REQ-016 i_invalid=1 SHALL set V for any class.
REQ-017 o_flags SHALL be updated as o_flags <= (i_flag_clr ? 0 : o_flags) | (o_valid_next ? cause_next : 0); when clear and set occur in the same cycle, the new cause SHALL survive.
REQ-018 i_flush=1 SHALL zero both stage valids on the next edge; an input valid in the flush cycle SHALL be dropped; o_cause and o_flags SHALL NOT be updated by killed entries.
REQ-019 Data and cause registers SHALL load only when their stage valid=1 and SHALL otherwise hold.
REQ-020 o_data, o_tag and o_cause SHALL be meaningful only while o_valid=1.

Reset
REQ-021 rst_n=0 SHALL immediately force o_valid=0, both stage valids to 0, o_flags=0, o_cause=0, o_data=0 and o_tag=0, independent of clk.
REQ-022 Entries in flight when reset asserts SHALL be discarded and SHALL NOT emerge after release.
REQ-023 The first input accepted after release SHALL appear 2 cycles later.

Verification
REQ-024 1.0 (exp=0, frac=0, RN) -> o_data=0x3F800000 and o_cause=0, with o_valid high exactly 2 cycles after i_valid.
REQ-025 exp=0, frac[24:2]=0x000001, guard=1, sticky=0 -> RN: 0x3F800002 with cause 0x01; RZ: 0x3F800001 with cause 0x01.
REQ-026 exp=0, frac[24:2]=0x7FFFFF, guard=1, RN -> carry-out giving 0x40000000 with cause 0x01; exp=128 -> RN: 0x7F800000 with cause 0x05, RZ: 0x7F7FFFFF with cause 0x05.
REQ-027 sign=1, exp=-127 -> 0x80000000 with cause 0x03; is_nan=1 with i_invalid=1 -> 0x7FBFFFFF with cause 0x10, and o_flags accumulates to 0x13 across the two results.
REQ-028 Back-to-back 4 inputs with tags 1..4 -> 4 consecutive o_valid cycles in tag order; i_flush asserted while tags 3 and 4 are in flight -> only tags 1 and 2 emerge; i_flag_clr in the same cycle as a cause-carrying result -> o_flags equals that result's cause.
REQ-029 rst_n pulsed low asynchronously with 2 entries in flight -> o_valid drops immediately, o_flags=0, and nothing emerges after release.
